// File: rtl/board_state_ram_pkg.sv
// Shared encodings for the Battleship board store, its renderer and the game logic.
// Tile codes, command opcodes, response codes and grid defaults live here.
package board_state_ram_pkg;

  localparam int GRID_DIM_DEF       = 10;
  localparam int MAX_SHIP_CELLS_DEF = 17;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_MISS  = 2'd1,
    TILE_HIT   = 2'd2,
    TILE_SHIP  = 2'd3
  } tile_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_PLACE = 2'd1,
    OP_FIRE  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    RSP_MISS     = 3'd0,
    RSP_HIT      = 3'd1,
    RSP_REPEAT   = 3'd2,
    RSP_PLACED   = 3'd3,
    RSP_OCCUPIED = 3'd4,
    RSP_FULL     = 3'd5,
    RSP_BADCOORD = 3'd6,
    RSP_CLEARED  = 3'd7
  } rsp_e;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_READ    = 2'd2,
    ST_RESOLVE = 2'd3
  } state_e;

  function automatic logic in_grid(input logic [3:0] x, input logic [3:0] y,
                                   input logic [4:0] dim);
    return ({1'b0, x} < dim) && ({1'b0, y} < dim);
  endfunction

endpackage

// File: rtl/board_dp_ram.sv
// 256x2 dual-port synchronous tile RAM: port A serves commands, port B serves video.
// Both ports are read-first, so a same-cycle write is not visible until the next read.
module board_dp_ram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_en_i,
  input  logic       a_we_i,
  input  logic [7:0] a_addr_i,
  input  logic [1:0] a_wdata_i,
  output logic [1:0] a_rdata_o,
  input  logic [7:0] b_addr_i,
  output logic [1:0] b_rdata_o
);

  logic [1:0] mem_q [256];
  logic [1:0] a_rdata_q;
  logic [1:0] b_rdata_q;

  // Command port: read-first read/write
  always_ff @(posedge clk) begin
    if (a_en_i) begin
      if (a_we_i) begin
        mem_q[a_addr_i] <= a_wdata_i;
      end
      a_rdata_q <= mem_q[a_addr_i];
    end
  end

  // Video port: read-only, output register cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdata_q <= 2'd0;
    end else begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/board_state_ram.sv
// One player's 10x10 Battleship board: command port for place/fire/clear,
// independent video read port for the renderer, and a remaining-ship-cell count.
module board_state_ram
  import board_state_ram_pkg::*;
#(
  parameter int GRID_DIM       = GRID_DIM_DEF,
  parameter int MAX_SHIP_CELLS = MAX_SHIP_CELLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vid_addr,
  output logic [1:0] vid_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  output logic       rsp_valid,
  output logic [2:0] rsp_code,
  output logic [4:0] ships_left,
  output logic       all_sunk
);

  state_e     state_q,      state_d;
  logic [7:0] clr_addr_q,   clr_addr_d;
  logic       clr_by_cmd_q, clr_by_cmd_d;
  op_e        op_q,         op_d;
  logic [7:0] addr_q,       addr_d;
  logic       wr_en_q,      wr_en_d;
  tile_e      wr_tile_q,    wr_tile_d;
  logic       rsp_valid_q,  rsp_valid_d;
  rsp_e       rsp_code_q,   rsp_code_d;
  logic [4:0] ships_left_q, ships_left_d;
  logic       placed_q,     placed_d;
  logic       all_sunk_q,   all_sunk_d;
  logic       cmd_ready_q,  cmd_ready_d;

  logic       ram_en_s;
  logic       ram_we_s;
  logic [7:0] ram_addr_s;
  logic [1:0] ram_wdata_s;
  logic [1:0] ram_rdata_s;
  tile_e      rd_tile_s;
  logic       handshake_s;
  logic       unused_vid_hi_s;

  assign unused_vid_hi_s = ^vid_addr[9:8];
  assign handshake_s     = cmd_valid && cmd_ready_q;
  assign rd_tile_s       = tile_e'(ram_rdata_s);

  board_dp_ram u_ram (
    .clk       (clk),
    .rst_n     (rst),
    .a_en_i    (ram_en_s),
    .a_we_i    (ram_we_s),
    .a_addr_i  (ram_addr_s),
    .a_wdata_i (ram_wdata_s),
    .a_rdata_o (ram_rdata_s),
    .b_addr_i  (vid_addr[7:0]),
    .b_rdata_o (vid_data)
  );

  // Next-state, RAM port A control and response decode
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_by_cmd_d = clr_by_cmd_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_tile_d    = wr_tile_q;
    rsp_valid_d  = 1'b0;
    rsp_code_d   = rsp_code_q;
    ships_left_d = ships_left_q;
    placed_d     = placed_q;
    all_sunk_d   = (ships_left_q == 5'd0) && placed_q;
    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_addr_s   = addr_q;
    ram_wdata_s  = wr_tile_q;

    case (state_q)
      ST_CLEAR: begin
        ram_en_s    = 1'b1;
        ram_we_s    = 1'b1;
        ram_addr_s  = clr_addr_q;
        ram_wdata_s = TILE_EMPTY;
        clr_addr_d  = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) begin
          state_d      = ST_IDLE;
          ships_left_d = 5'd0;
          placed_d     = 1'b0;
          clr_by_cmd_d = 1'b0;
          rsp_valid_d  = clr_by_cmd_q;
          rsp_code_d   = clr_by_cmd_q ? RSP_CLEARED : rsp_code_q;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (handshake_s) begin
          op_d   = op_e'(cmd_op);
          addr_d = {cmd_x, cmd_y};
          case (op_e'(cmd_op))
            OP_CLEAR: begin
              state_d      = ST_CLEAR;
              clr_addr_d   = 8'd0;
              clr_by_cmd_d = 1'b1;
            end
            OP_PLACE, OP_FIRE: begin
              if (in_grid(cmd_x, cmd_y, 5'(GRID_DIM))) begin
                // Read issued on the handshake edge so the tile is ready in READ
                ram_en_s   = 1'b1;
                ram_addr_s = {cmd_x, cmd_y};
                state_d    = ST_READ;
              end else begin
                rsp_valid_d = 1'b1;
                rsp_code_d  = RSP_BADCOORD;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d     = ST_RESOLVE;
        rsp_valid_d = 1'b1;
        case (op_q)
          OP_PLACE: begin
            if (rd_tile_s != TILE_EMPTY) begin
              rsp_code_d = RSP_OCCUPIED;
            end else if (ships_left_q == 5'(MAX_SHIP_CELLS)) begin
              rsp_code_d = RSP_FULL;
            end else begin
              wr_en_d      = 1'b1;
              wr_tile_d    = TILE_SHIP;
              ships_left_d = ships_left_q + 5'd1;
              placed_d     = 1'b1;
              rsp_code_d   = RSP_PLACED;
            end
          end
          OP_FIRE: begin
            case (rd_tile_s)
              TILE_EMPTY: begin
                wr_en_d    = 1'b1;
                wr_tile_d  = TILE_MISS;
                rsp_code_d = RSP_MISS;
              end
              TILE_SHIP: begin
                wr_en_d      = 1'b1;
                wr_tile_d    = TILE_HIT;
                ships_left_d = ships_left_q - 5'd1;
                rsp_code_d   = RSP_HIT;
              end
              default: begin
                rsp_code_d = RSP_REPEAT;
              end
            endcase
          end
          default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
          end
        endcase
      end
      ST_RESOLVE: begin
        ram_en_s    = wr_en_q;
        ram_we_s    = wr_en_q;
        ram_addr_s  = addr_q;
        ram_wdata_s = wr_tile_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // No new command while a response is on the bus
    cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= 8'd0;
      clr_by_cmd_q <= 1'b0;
      op_q         <= OP_NOP;
      addr_q       <= 8'd0;
      wr_en_q      <= 1'b0;
      wr_tile_q    <= TILE_EMPTY;
      rsp_valid_q  <= 1'b0;
      rsp_code_q   <= RSP_MISS;
      ships_left_q <= 5'd0;
      placed_q     <= 1'b0;
      all_sunk_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_by_cmd_q <= clr_by_cmd_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_tile_q    <= wr_tile_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_code_q   <= rsp_code_d;
      ships_left_q <= ships_left_d;
      placed_q     <= placed_d;
      all_sunk_q   <= all_sunk_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_code   = rsp_code_q;
  assign ships_left = ships_left_q;
  assign all_sunk   = all_sunk_q;

endmodule

// File: tb/tb_board_state_ram.sv
// Self-checking bench for board_state_ram: directed scenarios plus random
// place/fire traffic compared against a board-level reference model.
module tb_board_state_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] vid_addr = 10'd0;
  logic [1:0] vid_data;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_x = 4'd0;
  logic [3:0] cmd_y = 4'd0;
  logic       rsp_valid;
  logic [2:0] rsp_code;
  logic [4:0] ships_left;
  logic       all_sunk;

  int checks = 0;
  int errors = 0;

  // Reference model: tile per {x,y}, ship count, placed flag
  logic [1:0] board_m [256];
  int         ships_m;
  bit         placed_m;

  board_state_ram dut (
    .clk        (clk),
    .rst        (rst),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .ships_left (ships_left),
    .all_sunk   (all_sunk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) board_m[i] = 2'd0;
    ships_m  = 0;
    placed_m = 0;
  endtask

  // Game rules: returns expected code, latency (cycles after handshake) and whether a response exists
  task automatic model_cmd(input int op, input int x, input int y,
                           output int code, output int lat, output bit has_rsp);
    int t;
    has_rsp = 1;
    code    = 0;
    lat     = 2;
    if (op == 0) begin
      has_rsp = 0;
    end else if (op == 3) begin
      model_clear();
      code = 7;
      lat  = 257;
    end else if (x >= 10 || y >= 10) begin
      code = 6;
      lat  = 1;
    end else begin
      t = int'(board_m[x*16+y]);
      if (op == 1) begin
        if (t != 0)              code = 4;
        else if (ships_m == 17)  code = 5;
        else begin
          board_m[x*16+y] = 2'd3;
          ships_m++;
          placed_m = 1;
          code = 3;
        end
      end else begin
        if (t == 0) begin
          board_m[x*16+y] = 2'd1;
          code = 0;
        end else if (t == 3) begin
          board_m[x*16+y] = 2'd2;
          ships_m--;
          code = 1;
        end else begin
          code = 2;
        end
      end
    end
  endtask

  task automatic run_cmd(input string tag, input int op, input int x, input int y,
                         output logic [2:0] got);
    int ecode, elat, n;
    bit ersp;
    model_cmd(op, x, y, ecode, elat, ersp);
    got = 3'd0;
    @(negedge clk);
    cmd_op = 2'(op); cmd_x = 4'(x); cmd_y = 4'(y); cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 600) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(n < 600), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!ersp) begin
      n = 0;
      for (int i = 0; i < 3; i++) begin
        if (rsp_valid) n++;
        @(negedge clk);
      end
      check({tag, "_norsp"}, 32'(n), 32'd0);
    end else begin
      n = 1;
      while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
      got = rsp_code;
      check({tag, "_lat"}, 32'(n), 32'(elat));
      check({tag, "_code"}, 32'(rsp_code), 32'(ecode));
      check({tag, "_ships"}, 32'(ships_left), 32'(ships_m));
      @(negedge clk);
      check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, "_sunk"}, 32'(all_sunk), 32'(placed_m && ships_m == 0));
    end
  endtask

  task automatic vid_one(input string tag, input logic [7:0] a, input logic [1:0] exp);
    @(negedge clk);
    vid_addr = {2'b10, a};
    @(negedge clk);
    check(tag, 32'(vid_data), 32'(exp));
  endtask

  task automatic vid_sweep(input string tag);
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) check(tag, 32'(vid_data), 32'(board_m[i-1]));
      if (i < 256) vid_addr = {2'($urandom_range(0, 3)), 8'(i)};
    end
  endtask

  initial begin
    logic [2:0] got;
    int n, x, y, op;
    bit seen;

    model_clear();
    // Reset with cmd_valid held through the power-up sweep
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_code", 32'(rsp_code), 32'd0);
    check("rst_ships", 32'(ships_left), 32'd0);
    check("rst_sunk", 32'(all_sunk), 32'd0);
    check("rst_vid", 32'(vid_data), 32'd0);
    rst = 1'b1;
    n = 0; seen = 0;
    while (!cmd_ready && n < 600) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      n++;
    end
    cmd_valid = 1'b0;
    check("pwr_sweep_len", 32'(n), 32'd256);
    check("pwr_no_rsp", 32'(seen), 32'd0);
    check("pwr_ships", 32'(ships_left), 32'd0);
    check("pwr_sunk", 32'(all_sunk), 32'd0);
    vid_sweep("pwr_vid");

    // Place, occupied, bad coordinate
    run_cmd("place34", 1, 3, 4, got);
    check("place34_const", 32'(got), 32'd3);
    check("place34_ships_const", 32'(ships_left), 32'd1);
    run_cmd("occ34", 1, 3, 4, got);
    check("occ34_const", 32'(got), 32'd4);
    run_cmd("bad120", 1, 12, 0, got);
    check("bad120_const", 32'(got), 32'd6);
    run_cmd("badfire", 2, 0, 15, got);
    run_cmd("nop", 0, 3, 4, got);
    vid_one("vid34", 8'h34, 2'd3);

    run_cmd("clr1", 3, 0, 0, got);
    check("clr1_const", 32'(got), 32'd7);
    vid_one("clr1_vid34", 8'h34, 2'd0);

    // Place, hit, repeat, miss
    run_cmd("p00", 1, 0, 0, got);
    run_cmd("hit00", 2, 0, 0, got);
    check("hit00_const", 32'(got), 32'd1);
    check("hit00_sunk_const", 32'(all_sunk), 32'd1);
    run_cmd("rep00", 2, 0, 0, got);
    check("rep00_const", 32'(got), 32'd2);
    run_cmd("miss11", 2, 1, 1, got);
    check("miss11_const", 32'(got), 32'd0);
    vid_one("vid00", 8'h00, 2'd2);
    vid_one("vid11", 8'h11, 2'd1);

    // Fill to capacity, then one more
    while (ships_m < 17) begin
      x = $urandom_range(0, 9); y = $urandom_range(0, 9);
      if (board_m[x*16+y] == 2'd0) run_cmd("fill", 1, x, y, got);
    end
    check("fill_ships_const", 32'(ships_left), 32'd17);
    n = 0;
    while (n == 0) begin
      x = $urandom_range(0, 9); y = $urandom_range(0, 9);
      if (board_m[x*16+y] == 2'd0) begin
        run_cmd("full", 1, x, y, got);
        n = 1;
      end
    end
    check("full_const", 32'(got), 32'd5);
    check("full_ships_const", 32'(ships_left), 32'd17);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9) < 6 ? 2 : ($urandom_range(0, 4) == 0 ? 0 : 1);
      x  = $urandom_range(0, 7) == 0 ? $urandom_range(10, 15) : $urandom_range(0, 9);
      y  = $urandom_range(0, 9);
      run_cmd("rand", op, x, y, got);
    end
    // Sink every remaining ship
    for (int i = 0; i < 256; i++) begin
      if (board_m[i] == 2'd3) run_cmd("sink", 2, i / 16, i % 16, got);
    end
    check("sunk_all", 32'(all_sunk), 32'(placed_m));
    vid_sweep("play_vid");

    run_cmd("clr2", 3, 0, 0, got);
    check("clr2_ships", 32'(ships_left), 32'd0);
    check("clr2_sunk", 32'(all_sunk), 32'd0);
    vid_sweep("clr2_vid");

    // Reset while a FIRE is in flight
    run_cmd("p55", 1, 5, 5, got);
    @(negedge clk);
    cmd_op = 2'd2; cmd_x = 4'd5; cmd_y = 4'd5; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 600) begin @(negedge clk); n++; end
    check("abort_ready", 32'(n < 600), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_ships", 32'(ships_left), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    n = 0; seen = 0;
    while (!cmd_ready && n < 600) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("abort_sweep_len", 32'(n), 32'd256);
    check("abort_no_rsp", 32'(seen), 32'd0);
    check("abort_ships2", 32'(ships_left), 32'd0);
    check("abort_sunk", 32'(all_sunk), 32'd0);
    vid_sweep("abort_vid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
